scan_decoder: RTL and testbench

Parametrised, registered W-to-2^W one-hot decoder with a built-in scan sequencer. In direct mode it decodes an externally supplied index. In scan mode it steps its own index through every output at a programmable rate, for digit/row multiplexing and lab stimulus. It sits between lab control logic and the display/LED drivers, replacing the bare combinational decoder.

---
 rtl/scan_decoder_pkg.sv | 23 ++
 rtl/scan_decoder_tick.sv | 28 ++
 rtl/scan_decoder.sv | 78 +++++++
 tb/tb_scan_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared constants, FSM state type and the one-hot helper for the scan decoder.
package scan_decoder_pkg;

    localparam int MAX_W = 8;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    // Callers truncate the result to their own 2^w lines.
    function automatic logic [2**MAX_W-1:0] onehot(input logic [MAX_W-1:0] idx, input int w);
        logic [2**MAX_W-1:0] r;
        r = '0;
        if (int'(idx) < (1 << w))
            r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/scan_decoder_tick.sv
// Scan prescaler: counts 0..DIV-1 while running and flags the terminal count.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);

    logic [PCW-1:0] pc;

    assign tick = run && (pc == PC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (clr)
            pc <= '0;
        else if (run)
            pc <= tick ? '0 : pc + PCW'(1);
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered W-to-2^W one-hot decoder with direct indexing or a self-stepping scan index.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int W          = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [W-1:0]    i,
    input  logic            load,
    output logic [2**W-1:0] d,
    output logic [W-1:0]    idx,
    output logic            wrap
);

    localparam int N = 2**W;
    localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    state_t         state, state_n;
    logic           pc_clr, scan_run, tick;
    logic [W-1:0]   idx_n;
    logic [N-1:0]   d_n;
    logic           wrap_n;

    // Prescaler restarts whenever scanning is interrupted, so a resumed scan waits a full DIV.
    assign scan_run = en && (mode == MODE_SCAN);
    assign pc_clr   = !en || (mode == MODE_DIRECT) || load;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pc_clr),
        .run   (scan_run),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        case (state)
            OFF:     if (en)  state_n = RUN;
            RUN:     if (!en) state_n = OFF;
            default: state_n = OFF;
        endcase
    end

    always_comb begin
        idx_n  = idx;
        wrap_n = 1'b0;
        if (en) begin
            if (mode == MODE_DIRECT || load) begin
                idx_n = i;
            end else if (tick) begin
                idx_n  = idx + W'(1);
                wrap_n = (idx == {W{1'b1}});
            end
        end
        d_n = en ? (N'(onehot(MAX_W'(idx_n), W)) ^ INACTIVE) : INACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            idx   <= '0;
            d     <= INACTIVE;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            d     <= d_n;
            wrap  <= wrap_n;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: three parameterisations share stimulus, a monitor checks a queue.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [2:0] i = 3'd0;

    logic [7:0] d_a, d_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;
    logic [3:0] d_c;
    logic [1:0] idx_c;
    logic       wrap_c;

    always #5 clk = ~clk;

    scan_decoder #(.W(3), .DIV(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i), .load(load),
        .d(d_a), .idx(idx_a), .wrap(wrap_a)
    );

    scan_decoder #(.W(3), .DIV(4), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i), .load(load),
        .d(d_b), .idx(idx_b), .wrap(wrap_b)
    );

    scan_decoder #(.W(2), .DIV(1), .ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i[1:0]), .load(load),
        .d(d_c), .idx(idx_c), .wrap(wrap_c)
    );

    // Entry: {c_chk, c_d[3:0], c_idx[1:0], c_wrap, a_d[7:0], a_idx[2:0], a_wrap}
    localparam int EW = 20;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one registered result per clock, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("dut_a", 32'({d_a, idx_a, wrap_a}), 32'(mon_e[11:0]));
                check("dut_b_active_low", 32'({d_b, idx_b, wrap_b}), 32'({~mon_e[11:4], mon_e[3:0]}));
                if (mon_e[19])
                    check("dut_c_w2_div1", 32'({d_c, idx_c, wrap_c}), 32'(mon_e[18:12]));
            end
        end
    end

    task automatic step(input logic en_v, input logic mode_v, input logic [2:0] i_v, input logic load_v,
                        input logic [7:0] ed, input logic [2:0] ei, input logic ew,
                        input logic cc, input logic [3:0] ecd, input logic [1:0] eci, input logic ecw);
        @(negedge clk);
        en   = en_v;
        mode = mode_v;
        i    = i_v;
        load = load_v;
        exp_q.push_back({cc, ecd, eci, ecw, ed, ei, ew});
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'({d_a, idx_a, wrap_a}), 32'(12'h000));
        check("async_rst_b", 32'({d_b, idx_b, wrap_b}), 32'(12'hFF0));
        check("async_rst_c", 32'({d_c, idx_c, wrap_c}), 32'(7'h00));
        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ia, ic;

        // Held in reset with en toggling.
        for (int k = 0; k < 4; k++)
            step(k[0], 1'b0, 3'd5, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;

        // Direct sweep; load must be ignored in direct mode.
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 3'(k), k[0], 8'(1) << k, 3'(k), 1'b0,
                 1'b1, 4'(1) << (k % 4), 2'(k % 4), 1'b0);

        async_reset();

        // Scan from reset: A steps every 4 cycles, C every cycle.
        for (int k = 1; k <= 43; k++) begin
            ia = (k / 4) % 8;
            ic = k % 4;
            step(1'b1, 1'b1, 3'd0, 1'b0, 8'(1) << ia, 3'(ia), (k % 32 == 0),
                 1'b1, 4'(1) << ic, 2'(ic), (ic == 0));
        end

        // Load on A's step edge at idx 2: load wins.
        step(1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 3'd6, 1'b0, 1'b1, 4'h4, 2'd2, 1'b0);
        for (int j = 1; j <= 28; j++) begin
            ia = (6 + j / 4) % 8;
            ic = (2 + j) % 4;
            step(1'b1, 1'b1, 3'd0, 1'b0, 8'(1) << ia, 3'(ia), (j % 4 == 0) && (ia == 0),
                 1'b1, 4'(1) << ic, 2'(ic), (ic == 0));
        end

        // Disable at idx 5 for 10 cycles.
        for (int j = 0; j < 10; j++)
            step(1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 3'd5, 1'b0, 1'b1, 4'h0, 2'd2, 1'b0);

        // Re-enable resumes at 5 with a fresh prescale.
        for (int j = 1; j <= 4; j++) begin
            ia = (j == 4) ? 6 : 5;
            ic = (2 + j) % 4;
            step(1'b1, 1'b1, 3'd0, 1'b0, 8'(1) << ia, 3'(ia), 1'b0,
                 1'b1, 4'(1) << ic, 2'(ic), (ic == 0));
        end
        for (int j = 1; j <= 20; j++) begin
            ia = (6 + j / 4) % 8;
            ic = (2 + j) % 4;
            step(1'b1, 1'b1, 3'd0, 1'b0, 8'(1) << ia, 3'(ia), (j % 4 == 0) && (ia == 0),
                 1'b1, 4'(1) << ic, 2'(ic), (ic == 0));
        end

        // A is at idx 3 here.
        async_reset();

        // Direct then scan: scanning starts from the direct index.
        step(1'b1, 1'b0, 3'd5, 1'b0, 8'h20, 3'd5, 1'b0, 1'b1, 4'h2, 2'd1, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            ia = (j == 4) ? 6 : 5;
            ic = (1 + j) % 4;
            step(1'b1, 1'b1, 3'd0, 1'b0, 8'(1) << ia, 3'(ia), 1'b0,
                 1'b1, 4'(1) << ic, 2'(ic), (ic == 0));
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
